h_mul16_seq: RTL and testbench
==============================

Name: h_mul16_seq

Overview:
- Sequential 16x16 unsigned shift-add multiplier.
- Sits directly downstream of the 16-bit AND gate array: each step gates the shifted multiplicand with one replicated multiplier bit using two hAnd16 instances (low and high halves of a 32-bit partial product), then accumulates the result.
- Supplies the ALU/CPU datapath with a 32-bit product through a start/busy/done handshake.

Parameters:
- EARLY_EXIT, 0: when 1, finish as soon as the remaining multiplier bits are all zero. When 0, always run exactly 16 steps.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse, high while in DONE
- product  output  32  registered a*b
- overflow  output  1  registered, equals (product[31:16] != 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; assertion forces all state immediately, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, product=0, overflow=0. Internal registers are cleared: a_sh (32b), b_sh (16b), acc (32b), cnt (4b).
- IDLE:
  - On a rising edge with start=1: a_sh={16'h0,a}, b_sh=b, acc=0, cnt=0, and state goes to RUN.
  - a and b are captured only at this edge; later changes to the inputs have no effect.
  - With start=0, the block stays in IDLE.
- RUN (one step per edge):
  - pp = a_sh AND {32{b_sh[0]}}, built from the two hAnd16 instances.
  - acc <= acc + pp (32-bit; cannot overflow for 16x16).
  - a_sh <= a_sh << 1; b_sh <= b_sh >> 1; cnt <= cnt + 1.
  - Go to DONE when cnt==15, or when EARLY_EXIT=1 and (b_sh>>1)==0.
  - On that same edge, product <= acc+pp and overflow <= ((acc+pp)[31:16]!=0).
- DONE: lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
- Latency with EARLY_EXIT=0:
  - Accept edge E0; step edges E1..E16.
  - done is high in the cycle following E16, and product is valid from E16 on.
- Latency with EARLY_EXIT=1:
  - Number of steps = max(1, index of the highest set bit of b + 1).
  - b=0 takes 1 step, with product=0.
- start while busy=1 (RUN or DONE) is ignored; there is no queueing.
  - A start held high through DONE is accepted on the first IDLE edge, i.e. the edge after DONE.
- product and overflow hold their last value until the next completion. They are not cleared on start.
- Reset asserted mid-RUN aborts the operation immediately: all outputs take their reset values, and no done pulse is issued for the aborted operation.
- busy goes high on the accept edge E0 and low on the exit edge from DONE.

Test Plan:
- Reset, then start with a=3, b=5 (EARLY_EXIT=0) -> busy=1 from E0; done=1 for exactly one cycle after E16; product=32'h0000000F; overflow=0; busy=0 after the next edge.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001, overflow=1. Follow with a=0, b=16'h1234 -> product=0, overflow=0.
- During RUN of a=7, b=9, pulse start with a=2, b=2 at step 5 -> the second request is ignored; product=63; exactly one done pulse.
- Assert rst_n=0 at step 8 of a=100, b=200, release, then start a=10, b=20 -> outputs are 0 during reset; no done for the aborted operation; the next result is product=200 after 16 steps.
- EARLY_EXIT=1, b=1, a=16'hABCD -> done one cycle after E1, product=32'h0000ABCD. Then b=0 -> 1 step, product=0. Then b=16'h8000, a=2 -> 16 steps, product=32'h00010000, overflow=1.
- start held high continuously with a=4, b=4 -> back-to-back operations: each done pulse is followed by IDLE for one cycle, then re-acceptance; product=16 every time.

Source files
------------

// File: rtl/h_mul16_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential 16x16 multiplier.
interface h_mul16_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        overflow;

    // Requester side: issues start with operands, observes status and result
    modport master (
        output start, a, b,
        input  busy, done, product, overflow
    );

    // Multiplier side
    modport slave (
        input  start, a, b,
        output busy, done, product, overflow
    );
endinterface

// File: rtl/h_mul16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier.
// Each RUN step gates the shifted multiplicand with the current multiplier LSB
// through two 16-bit AND arrays (low/high halves of the 32-bit partial product)
// and accumulates. Optional early exit once the remaining multiplier bits are zero.

// 16-bit bitwise AND gate array
module hAnd16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign y[gi] = a[gi] & b[gi];
        end
    endgenerate
endmodule

module h_mul16_seq #(
    parameter int EARLY_EXIT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    h_mul16_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam bit EE = (EARLY_EXIT != 0);

    state_t      state_q,    state_d;
    logic [31:0] a_sh_q,     a_sh_d;
    logic [15:0] b_sh_q,     b_sh_d;
    logic [31:0] acc_q,      acc_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [31:0] product_q,  product_d;
    logic        overflow_q, overflow_d;

    logic [15:0] bit_rep;
    logic [31:0] pp;
    logic [31:0] acc_sum;
    logic        last_step;

    // Current multiplier bit replicated across a half-word
    assign bit_rep = {16{b_sh_q[0]}};

    hAnd16 u_and_lo (
        .a (a_sh_q[15:0]),
        .b (bit_rep),
        .y (pp[15:0])
    );

    hAnd16 u_and_hi (
        .a (a_sh_q[31:16]),
        .b (bit_rep),
        .y (pp[31:16])
    );

    // 16x16 product fits in 32 bits, so this sum never wraps
    assign acc_sum   = acc_q + pp;
    // b_sh_q[15:1] is what the multiplier register holds after this step
    assign last_step = (cnt_q == 4'd15) || (EE && (b_sh_q[15:1] == 15'd0));

    // Next-state and datapath updates for the accept/step/complete sequence
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = {16'h0000, bus.a};
                    b_sh_d  = bus.b;
                    acc_d   = 32'h0;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = acc_sum;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 4'd1;
                if (last_step) begin
                    state_d    = S_DONE;
                    product_d  = acc_sum;
                    overflow_d = (acc_sum[31:16] != 16'h0000);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_sh_q     <= 32'h0;
            b_sh_q     <= 16'h0;
            acc_q      <= 32'h0;
            cnt_q      <= 4'd0;
            product_q  <= 32'h0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.product  = product_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_h_mul16_seq.sv
// Self-checking bench for h_mul16_seq: one instance with fixed 16-step latency,
// one with early exit, both checked against an arithmetic reference model.
module tb_h_mul16_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    h_mul16_seq_if if0 ();
    h_mul16_seq_if if1 ();

    h_mul16_seq #(.EARLY_EXIT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    h_mul16_seq #(.EARLY_EXIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_prod [2];

    task automatic drive(input bit ee, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (ee) begin
            if1.start = s; if1.a = a; if1.b = b;
        end else begin
            if0.start = s; if0.a = a; if0.b = b;
        end
    endtask

    function automatic logic f_busy(input bit ee);
        return ee ? if1.busy : if0.busy;
    endfunction
    function automatic logic f_done(input bit ee);
        return ee ? if1.done : if0.done;
    endfunction
    function automatic logic [31:0] f_prod(input bit ee);
        return ee ? if1.product : if0.product;
    endfunction
    function automatic logic f_ovf(input bit ee);
        return ee ? if1.overflow : if0.overflow;
    endfunction

    // Reference: number of steps from the multiplier's highest set bit
    function automatic int exp_steps(input bit ee, input logic [15:0] b);
        if (!ee) return 16;
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    // One full operation with cycle-accurate handshake checks
    task automatic do_op(input bit ee, input logic [15:0] a, input logic [15:0] b,
                         input int pulse_at, input string name);
        logic [31:0] ep;
        logic        eo;
        int          n;
        ep = {16'h0, a} * {16'h0, b};
        eo = (ep[31:16] != 16'h0);
        n  = exp_steps(ee, b);
        @(negedge clk);
        drive(ee, 1'b1, a, b);
        @(posedge clk); #1;
        drive(ee, 1'b0, 16'($urandom), 16'($urandom));
        checks++;
        if (f_busy(ee) !== 1'b1 || f_done(ee) !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, f_busy(ee), f_done(ee));
        end
        for (int k = 1; k <= n; k++) begin
            if (k == pulse_at) begin
                @(negedge clk);
                drive(ee, 1'b1, 16'd2, 16'd2);
            end
            @(posedge clk); #1;
            if (k == pulse_at) drive(ee, 1'b0, 16'($urandom), 16'($urandom));
            if (k < n) begin
                checks++;
                if (f_done(ee) !== 1'b0 || f_busy(ee) !== 1'b1) begin
                    errors++;
                    $display("FAIL %s step%0d: busy=%b done=%b required busy=1 done=0", name, k, f_busy(ee), f_done(ee));
                end
                if (k == 1) begin
                    checks++;
                    if (f_prod(ee) !== prev_prod[ee]) begin
                        errors++;
                        $display("FAIL %s hold: product=%h required %h", name, f_prod(ee), prev_prod[ee]);
                    end
                end
            end else begin
                checks++;
                if (f_done(ee) !== 1'b1 || f_busy(ee) !== 1'b1 || f_prod(ee) !== ep || f_ovf(ee) !== eo) begin
                    errors++;
                    $display("FAIL %s result: done=%b busy=%b product=%h ovf=%b required done=1 busy=1 product=%h ovf=%b",
                             name, f_done(ee), f_busy(ee), f_prod(ee), f_ovf(ee), ep, eo);
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (f_done(ee) !== 1'b0 || f_busy(ee) !== 1'b0 || f_prod(ee) !== ep) begin
            errors++;
            $display("FAIL %s exit: done=%b busy=%b product=%h required done=0 busy=0 product=%h",
                     name, f_done(ee), f_busy(ee), f_prod(ee), ep);
        end
        prev_prod[ee] = ep;
        $display("op %s ee=%0d a=%h b=%h steps=%0d product=%h ovf=%b", name, ee, a, b, n, f_prod(ee), f_ovf(ee));
    endtask

    task automatic check_reset_outputs(input string name);
        for (int e = 0; e < 2; e++) begin
            checks++;
            if (f_busy(e[0]) !== 1'b0 || f_done(e[0]) !== 1'b0 || f_prod(e[0]) !== 32'h0 || f_ovf(e[0]) !== 1'b0) begin
                errors++;
                $display("FAIL %s ee=%0d: busy=%b done=%b product=%h ovf=%b required all zero",
                         name, e, f_busy(e[0]), f_done(e[0]), f_prod(e[0]), f_ovf(e[0]));
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_prod[0] = 32'h0;
        prev_prod[1] = 32'h0;
        @(posedge clk); #1;
        check_reset_outputs("post_reset_idle");
        $display("reset released");
    endtask

    task automatic test_basic();
        do_op(1'b0, 16'd3, 16'd5, 0, "basic_3x5");
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 0, "max_x_max");
        do_op(1'b0, 16'h0000, 16'h1234, 0, "zero_a");
    endtask

    task automatic test_ignore_start();
        do_op(1'b0, 16'd7, 16'd9, 5, "ignore_start");
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start extra: done=%b busy=%b required 0 0", if0.done, if0.busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd100, 16'd200);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b required 0", if0.done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_prod[0] = 32'h0;
        prev_prod[1] = 32'h0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: done=%b busy=%b required 0 0", if0.done, if0.busy);
            end
        end
        $display("reset abort done");
        do_op(1'b0, 16'd10, 16'd20, 0, "after_abort");
    endtask

    task automatic test_early_exit();
        do_op(1'b1, 16'hABCD, 16'h0001, 0, "ee_b1");
        do_op(1'b1, 16'h1234, 16'h0000, 0, "ee_b0");
        do_op(1'b1, 16'h0002, 16'h8000, 0, "ee_b8000");
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            do_op(i[0], ra, rb, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd4, 16'd4);
        @(posedge clk); #1;
        checks++;
        if (if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: busy=%b required 1", if0.busy);
        end
        for (int op = 0; op < 3; op++) begin
            repeat (15) @(posedge clk);
            #1;
            checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b run%0d: done=%b busy=%b required 0 1", op, if0.done, if0.busy);
            end
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b1 || if0.product !== 32'd16 || if0.overflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b done%0d: done=%b product=%h ovf=%b required 1 00000010 0",
                         op, if0.done, if0.product, if0.overflow);
            end
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b idle%0d: done=%b busy=%b required 0 0", op, if0.done, if0.busy);
            end
            @(posedge clk); #1;
            checks++;
            if (if0.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b reaccept%0d: busy=%b required 1", op, if0.busy);
            end
            $display("op b2b%0d a=0004 b=0004 product=%h", op, if0.product);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (if0.busy !== 1'b0 || if0.product !== 32'd16) begin
            errors++;
            $display("FAIL b2b drain: busy=%b product=%h required 0 00000010", if0.busy, if0.product);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_early_exit();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
